// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT datapath stages.
// Twiddles are signed Q10 values held in 18-bit words.
package fft_pkg;
  localparam int N45     = 45;
  localparam int TW_W    = 18;
  localparam int TW_FRAC = 10;
  localparam int TW_RND  = 1 << (TW_FRAC - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } rot_state_t;

  // Returns {above max, below min} for v against a signed dw-bit range
  function automatic logic [1:0] sat_flags(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    sat_flags = {v > hi, v < lo};
  endfunction
endpackage

// File: rtl/cmult_q10.sv
// Two-stage signed complex multiply by a Q10 twiddle with round-half-up and saturation.
// Stage B registers the four partial products, stage C registers the rounded result.
module cmult_q10 import fft_pkg::*; #(
  parameter int DW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [DW-1:0]   i_re,
  input  logic signed [DW-1:0]   i_im,
  input  logic signed [TW_W-1:0] i_twr,
  input  logic signed [TW_W-1:0] i_twi,
  output logic signed [DW-1:0]   o_re,
  output logic signed [DW-1:0]   o_im
);
  localparam int PW = DW + TW_W;
  localparam int SW = PW + 1;
  localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

  logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [SW-1:0] w_pr_rnd, w_pi_rnd, w_pr_sh, w_pi_sh;
  logic [1:0] w_pr_flags, w_pi_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_rr <= '0;
      r_p_ii <= '0;
      r_p_ri <= '0;
      r_p_ir <= '0;
    end else begin
      r_p_rr <= PW'(i_re) * PW'(i_twr);
      r_p_ii <= PW'(i_im) * PW'(i_twi);
      r_p_ri <= PW'(i_re) * PW'(i_twi);
      r_p_ir <= PW'(i_im) * PW'(i_twr);
    end
  end

  assign w_pr_rnd = SW'(r_p_rr) - SW'(r_p_ii) + SW'(TW_RND);
  assign w_pi_rnd = SW'(r_p_ri) + SW'(r_p_ir) + SW'(TW_RND);
  assign w_pr_sh  = w_pr_rnd >>> TW_FRAC;
  assign w_pi_sh  = w_pi_rnd >>> TW_FRAC;
  assign w_pr_flags = sat_flags(64'(w_pr_sh), DW);
  assign w_pi_flags = sat_flags(64'(w_pi_sh), DW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_re <= '0;
      o_im <= '0;
    end else begin
      o_re <= w_pr_flags[1] ? MAXV : (w_pr_flags[0] ? MINV : w_pr_sh[DW-1:0]);
      o_im <= w_pi_flags[1] ? MAXV : (w_pi_flags[0] ? MINV : w_pi_sh[DW-1:0]);
    end
  end
endmodule

// File: rtl/twiddle_rotator45.sv
// Streaming W45^(n*k) rotator: frame FSM, incremental ROM address, stage A alignment
// and the valid/last pipe around the two-stage complex multiplier.
module twiddle_rotator45 import fft_pkg::*; #(
  parameter int DW     = 16,
  parameter int TW_LAT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [5:0]             k,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   in_re,
  input  logic signed [DW-1:0]   in_im,
  output logic [10:0]            tw_addr,
  input  logic signed [TW_W-1:0] tw_re,
  input  logic signed [TW_W-1:0] tw_im,
  output logic                   out_valid,
  output logic signed [DW-1:0]   out_re,
  output logic signed [DW-1:0]   out_im,
  output logic                   out_last
);
  localparam logic [5:0] N45_M  = 6'(N45);
  localparam logic [5:0] LAST_N = 6'(N45 - 1);

  rot_state_t r_state, w_state_next;
  logic [5:0] r_n, r_acc, r_kreg, w_acc_next;
  logic [6:0] w_acc_sum;
  logic w_accept, w_last_accept;
  logic [2:0] r_vld, r_lst;
  logic signed [DW-1:0] r_a_re, r_a_im;
  logic signed [TW_W-1:0] w_b_twr, w_b_twi;

  assign w_accept      = in_valid && in_ready;
  assign w_last_accept = w_accept && (r_n == LAST_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last_accept) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state == S_RUN);
    in_ready = (r_state == S_RUN);
  end

  // Both operands are below 45, so one conditional subtract keeps acc = n*k mod 45
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_kreg};
  always_comb begin
    w_acc_next = w_acc_sum[5:0];
    if (w_acc_sum >= {1'b0, N45_M}) w_acc_next = 6'(w_acc_sum - {1'b0, N45_M});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n    <= '0;
      r_acc  <= '0;
      r_kreg <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_n    <= '0;
      r_acc  <= '0;
      r_kreg <= (k >= N45_M) ? (k - N45_M) : k;
    end else if (w_accept) begin
      r_n   <= r_n + 6'd1;
      r_acc <= w_acc_next;
    end
  end

  assign tw_addr = {5'b0, r_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_re <= '0;
      r_a_im <= '0;
    end else begin
      r_a_re <= in_re;
      r_a_im <= in_im;
    end
  end

  // A registered ROM already presents the twiddle in stage A; a combinational one is captured here
  generate
    if (TW_LAT == 0) begin : g_tw_capture
      logic signed [TW_W-1:0] r_a_twr, r_a_twi;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a_twr <= '0;
          r_a_twi <= '0;
        end else begin
          r_a_twr <= tw_re;
          r_a_twi <= tw_im;
        end
      end
      assign w_b_twr = r_a_twr;
      assign w_b_twi = r_a_twi;
    end else begin : g_tw_direct
      assign w_b_twr = tw_re;
      assign w_b_twi = tw_im;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_vld <= {r_vld[1:0], w_accept};
      r_lst <= {r_lst[1:0], w_last_accept};
    end
  end

  cmult_q10 #(.DW(DW)) u_cmult (
    .clk   (clk),
    .rst_n (rst_n),
    .i_re  (r_a_re),
    .i_im  (r_a_im),
    .i_twr (w_b_twr),
    .i_twi (w_b_twi),
    .o_re  (out_re),
    .o_im  (out_im)
  );

  assign out_valid = r_vld[2];
  assign out_last  = r_lst[2];
endmodule

// File: tb/tb_twiddle_rotator45.sv
// Scoreboard bench: one rotator with a combinational ROM and one with a registered ROM share stimulus.
module tb_twiddle_rotator45;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [5:0] k = '0;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;

  logic busy0, busy1, rdy0, rdy1, ov0, ov1, ol0, ol1;
  logic [10:0] a0, a1;
  logic signed [17:0] twr0, twi0, twr1, twi1;
  logic signed [DW-1:0] ore0, oim0, ore1, oim1;

  always #5 clk = ~clk;

  int rom_re[45];
  int rom_im[45];

  assign twr0 = (a0 < 11'd45) ? 18'(rom_re[a0]) : '0;
  assign twi0 = (a0 < 11'd45) ? 18'(rom_im[a0]) : '0;
  always @(posedge clk) begin
    twr1 <= (a1 < 11'd45) ? 18'(rom_re[a1]) : '0;
    twi1 <= (a1 < 11'd45) ? 18'(rom_im[a1]) : '0;
  end

  twiddle_rotator45 #(.DW(DW), .TW_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k), .busy(busy0),
    .in_valid(in_valid), .in_ready(rdy0), .in_re(in_re), .in_im(in_im),
    .tw_addr(a0), .tw_re(twr0), .tw_im(twi0),
    .out_valid(ov0), .out_re(ore0), .out_im(oim0), .out_last(ol0)
  );

  twiddle_rotator45 #(.DW(DW), .TW_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k), .busy(busy1),
    .in_valid(in_valid), .in_ready(rdy1), .in_re(in_re), .in_im(in_im),
    .tw_addr(a1), .tw_re(twr1), .tw_im(twi1),
    .out_valid(ov1), .out_re(ore1), .out_im(oim1), .out_last(ol1)
  );

  typedef struct {
    int     re;
    int     im;
    bit     last;
    longint cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_vec = 0;
  int n_err = 0;
  longint cyc = 0;

  int s_re[45], s_im[45], hx_re[45], hx_im[45];
  bit hx[45];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic mon(input int d, input bit v, input int re, input int im, input bit last);
    exp_t e;
    bit have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (v) begin
      n_vec++;
      if (!have) begin
        n_err++;
        $display("FAIL dut%0d unexpected_out: got re=%0d im=%0d at cycle %0d, required no output", d, re, im, cyc);
      end else begin
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        $display("dut%0d out re=%0d im=%0d last=%0d cycle=%0d", d, re, im, last, cyc);
        if (re != e.re || im != e.im || last != e.last || cyc != e.cyc) begin
          n_err++;
          $display("FAIL dut%0d out_sample: got re=%0d im=%0d last=%0d cycle=%0d, required re=%0d im=%0d last=%0d cycle=%0d",
                   d, re, im, last, cyc, e.re, e.im, e.last, e.cyc);
        end
      end
    end else if (have && e.cyc <= cyc) begin
      n_vec++;
      n_err++;
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
      $display("FAIL dut%0d missing_out: got no output at cycle %0d, required re=%0d im=%0d", d, cyc, e.re, e.im);
    end
  endtask

  always @(negedge clk) begin
    mon(0, ov0, int'(ore0), int'(oim0), ol0);
    mon(1, ov1, int'(ore1), int'(oim1), ol1);
  end

  function automatic int rnd_sat(input longint p);
    longint r;
    r = (p + 512) >>> 10;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return int'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prep();
    for (int i = 0; i < 45; i++) begin
      s_re[i] = int'($urandom_range(65535)) - 32768;
      s_im[i] = int'($urandom_range(65535)) - 32768;
      hx[i] = 1'b0;
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid0", ov0, 0);  chk("rst_out_valid1", ov1, 0);
    chk("rst_out_last0", ol0, 0);   chk("rst_out_last1", ol1, 0);
    chk("rst_out_re0", ore0, 0);    chk("rst_out_re1", ore1, 0);
    chk("rst_out_im0", oim0, 0);    chk("rst_out_im1", oim1, 0);
    chk("rst_busy0", busy0, 0);     chk("rst_busy1", busy1, 0);
    chk("rst_in_ready0", rdy0, 0);  chk("rst_in_ready1", rdy1, 0);
    chk("rst_tw_addr0", a0, 0);     chk("rst_tw_addr1", a1, 0);
  endtask

  task automatic run_frame(input int kk, input int gap_pct, input bit poke, input int stop_n);
    int kr, addr, guard;
    bit poked;
    exp_t e;
    kr = (kk >= 45) ? kk - 45 : kk;
    guard = 0;
    poked = 1'b0;
    while (busy0 && guard < 200) begin
      step();
      guard++;
    end
    chk("idle_before_start", busy0, 0);
    chk("tw_addr_idle", a0, 0);
    start = 1'b1;
    k = 6'(kk);
    step();
    start = 1'b0;
    k = '0;
    for (int n = 0; n < stop_n; n++) begin
      while ((gap_pct > 0 && int'($urandom_range(99)) < gap_pct) || (poke && n == 10 && !poked)) begin
        in_valid = 1'b0;
        if (poke && n == 10 && !poked) begin
          start = 1'b1;
          k = 6'd7;
          poked = 1'b1;
        end
        step();
        start = 1'b0;
        k = '0;
      end
      in_valid = 1'b1;
      in_re = DW'(s_re[n]);
      in_im = DW'(s_im[n]);
      addr = (n * kr) % 45;
      chk("in_ready0", rdy0, 1);
      chk("in_ready1", rdy1, 1);
      chk("tw_addr0", a0, addr);
      chk("tw_addr1", a1, addr);
      e.re = hx[n] ? hx_re[n]
                   : rnd_sat(longint'(s_re[n]) * rom_re[addr] - longint'(s_im[n]) * rom_im[addr]);
      e.im = hx[n] ? hx_im[n]
                   : rnd_sat(longint'(s_re[n]) * rom_im[addr] + longint'(s_im[n]) * rom_re[addr]);
      e.last = (n == 44);
      e.cyc = cyc + 3;
      q0.push_back(e);
      q1.push_back(e);
      step();
    end
    in_valid = 1'b0;
    if (stop_n == 45) begin
      chk("busy_after_last", busy0, 0);
      chk("in_ready_after_last", rdy1, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    real ang;
    int guard;
    for (int i = 0; i < 45; i++) begin
      ang = 2.0 * 3.14159265358979 * i / 45.0;
      rom_re[i] = int'($floor(1024.0 * $cos(ang)));
      rom_im[i] = int'($floor(-1024.0 * $sin(ang)));
    end

    repeat (3) step();
    chk_reset_state();
    rst_n = 1'b1;
    step();

    // k=0: identity rotation
    prep();
    for (int i = 0; i < 45; i++) begin
      s_re[i] = 1000; s_im[i] = -500;
      hx[i] = 1'b1; hx_re[i] = 1000; hx_im[i] = -500;
    end
    run_frame(0, 0, 0, 45);

    prep();
    s_re[1] = 1024; s_im[1] = 0;
    hx[1] = 1'b1; hx_re[1] = 1014; hx_im[1] = -143;
    run_frame(1, 0, 0, 45);

    prep();
    run_frame(44, 0, 0, 45);
    prep();
    run_frame(46, 0, 0, 45);

    prep();
    s_re[1] = 32767; s_im[1] = -32768;
    hx[1] = 1'b1; hx_re[1] = 32767; hx_im[1] = 2399;
    run_frame(39, 0, 0, 45);

    // back-to-back frames with input gaps and an ignored mid-frame start
    prep();
    run_frame(7, 30, 1, 45);
    prep();
    run_frame(50, 30, 0, 45);
    prep();
    run_frame(22, 30, 1, 45);

    // reset with samples 18..20 still in the pipeline
    prep();
    run_frame(5, 0, 0, 21);
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk_reset_state();
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("post_reset_busy", busy0, 0);
    chk("post_reset_tw_addr", a1, 0);
    prep();
    run_frame(2, 0, 0, 45);

    guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 20) begin
      step();
      guard++;
    end
    chk("drain_dut0", q0.size(), 0);
    chk("drain_dut1", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
